// File: rtl/mult8x8_seq_ctrl.sv
// mult8x8_seq_ctrl: unsigned 8x8 multiply sequenced over one external 4x4 multiplier
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request a multiply (accepted in IDLE or DONE)
//   dataa   in   [7:0] multiplicand, latched on accept
//   datab   in   [7:0] multiplier, latched on accept
//   mult_a  out  [3:0] nibble to mult4x4 dataa
//   mult_b  out  [3:0] nibble to mult4x4 datab
//   mult_p  in   [7:0] mult4x4 product
//   product out  [15:0] last completed result
//   busy    out  high while in CALC
//   done    out  one-cycle pulse when product updates
module mult8x8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [3:0]  mult_a,
    output logic [3:0]  mult_b,
    input  logic [7:0]  mult_p,
    output logic [15:0] product,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a, b;
    logic [15:0] acc, pp;
    logic [3:0]  sh;
    // step[0] selects the high nibble of a, step[1] the high nibble of b
    always_comb begin
        mult_a = (state == CALC) ? (step[0] ? a[7:4] : a[3:0]) : 4'd0;
        mult_b = (state == CALC) ? (step[1] ? b[7:4] : b[3:0]) : 4'd0;
        sh     = (step == 2'd0) ? 4'd0 : (step == 2'd3) ? 4'd8 : 4'd4;
        pp     = {8'd0, mult_p} << sh;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= 2'd0;
            a       <= 8'd0;
            b       <= 8'd0;
            acc     <= 16'd0;
            product <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (state == CALC) begin
            acc  <= acc + pp;
            step <= step + 2'd1;
            if (step == 2'd3) begin
                product <= acc + pp;
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
            end
        end else begin
            done <= 1'b0;
            if (start) begin
                a     <= dataa;
                b     <= datab;
                acc   <= 16'd0;
                step  <= 2'd0;
                state <= CALC;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb_mult8x8_seq_ctrl: self-checking bench for mult8x8_seq_ctrl with a behavioural mult4x4
module tb_mult8x8_seq_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [7:0]  dataa = 8'd0, datab = 8'd0;
    logic [3:0]  mult_a, mult_b;
    logic [7:0]  mult_p;
    logic [15:0] product;
    logic        busy, done;
    int          checks = 0, errors = 0;
    logic [15:0] last = 16'd0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;
    vec_t vecs[10];

    logic [3:0] exp_a[4] = '{4'h5, 4'hA, 4'h5, 4'hA};
    logic [3:0] exp_b[4] = '{4'hC, 4'hC, 4'h3, 4'h3};
    logic [7:0] exp_p[4] = '{8'd60, 8'd120, 8'd15, 8'd30};

    mult8x8_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dataa(dataa), .datab(datab),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .product(product), .busy(busy), .done(done)
    );

    assign mult_p = mult_a * mult_b;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // accepts one multiply, checks hold of old product, latency, result and pulse width
    task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        int lat;
        lat = 0;
        dataa = x;
        datab = y;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (i < 4) chk("product_held", product, last);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, 4);
        chk("product", product, exp);
        chk("busy_at_done", busy, 0);
        last = exp;
        tick;
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int pulses;
        vecs[0] = '{8'hA5, 8'h3C, 16'd9900};
        vecs[1] = '{8'hFF, 8'hFF, 16'd65025};
        vecs[2] = '{8'h00, 8'h7B, 16'd0};
        vecs[3] = '{8'h10, 8'h10, 16'd256};
        for (int i = 4; i < 10; i++) begin
            vecs[i].a = 8'($urandom);
            vecs[i].b = 8'($urandom);
            vecs[i].p = 16'(vecs[i].a) * 16'(vecs[i].b);
        end

        // reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        dataa = 8'hA5;
        datab = 8'h3C;
        tick;
        tick;
        chk("rst_product", product, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick;
        chk("no_calc_after_rst", busy, 0);

        // nibble sequence for 0xA5 * 0x3C
        dataa = 8'hA5;
        datab = 8'h3C;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chk("seq_mult_a", mult_a, exp_a[s]);
            chk("seq_mult_b", mult_b, exp_b[s]);
            chk("seq_mult_p", mult_p, exp_p[s]);
            tick;
        end
        chk("seq_done", done, 1);
        chk("seq_product", product, 16'd9900);
        last = 16'd9900;
        tick;
        chk("seq_done_drop", done, 0);
        chk("idle_mult_a", mult_a, 0);
        chk("idle_mult_b", mult_b, 0);

        // table-driven vectors
        for (int i = 0; i < 10; i++) run(vecs[i].a, vecs[i].b, vecs[i].p);

        // start reasserted during CALC is ignored
        dataa = 8'hA5;
        datab = 8'h3C;
        start = 1'b1;
        tick;
        dataa = 8'hFF;
        datab = 8'hFF;
        for (int i = 0; i < 3; i++) tick;
        start = 1'b0;
        tick;
        chk("ign_done", done, 1);
        chk("ign_product", product, 16'd9900);
        last = 16'd9900;

        // start held in DONE: back-to-back accept, one done pulse per result
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("b2b_done_drop", done, 0);
        chk("b2b_busy", busy, 1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done) pulses++;
            if (done) chk("b2b_product", product, 16'h12 * 16'h34);
        end
        chk("b2b_pulses", pulses, 1);
        last = 16'h12 * 16'h34;

        // reset at step2 aborts with no done pulse
        dataa = 8'hFF;
        datab = 8'hFF;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        last = 16'd0;
        run(8'h10, 8'h10, 16'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
